// File: rtl/aer_in_arbiter.sv
// ----------------------------------------------------------------------------
// aer_in_arbiter
//
// Multi-channel AER input front-end. Each of NCH asynchronous 4-phase AER
// channels is synchronised, arbitrated round-robin and pushed into an event
// FIFO. The FIFO is drained by the core through a valid/ready stream. A full
// FIFO holds off new grants, so senders wait for ACK and no event is dropped.
//
// Optional feature macro: AER_TIMESTAMP_EN
//   defined   - TSW-bit counter of synchronised TIME_TICK rising edges; every
//               event carries the count from its grant cycle on o_evt_ts.
//   undefined - no counter, no o_evt_ts port, i_time_tick is ignored.
//
// Ports
//   i_clk          core clock
//   i_rst_n        synchronous active-low reset
//   i_aerin_addr   NCH*M  channel c address at [c*M +: M], stable while REQ high
//   i_aerin_req    NCH    asynchronous 4-phase requests
//   i_aerin_tar_en NCH    per-channel target flag, bundled with the address
//   o_aerin_ack    NCH    4-phase acknowledges (decoded from channel state regs)
//   i_time_tick    1      asynchronous time-step tick
//   o_evt_valid    1      FIFO head valid
//   i_evt_ready    1      core accepts head when valid & ready
//   o_evt_addr     M      head address
//   o_evt_ch       clog2(NCH) head source channel
//   o_evt_tar      1      head target flag
//   o_evt_ts       TSW    head timestamp (AER_TIMESTAMP_EN only)
//   o_fifo_level   clog2(DEPTH)+1 FIFO occupancy
//   o_stall        1      registered: some channel pending while FIFO full
// ----------------------------------------------------------------------------
module aer_in_arbiter #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned M     = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TSW   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NCH*M-1:0]         i_aerin_addr,
    input  logic [NCH-1:0]           i_aerin_req,
    input  logic [NCH-1:0]           i_aerin_tar_en,
    output logic [NCH-1:0]           o_aerin_ack,
    input  logic                     i_time_tick,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic [M-1:0]             o_evt_addr,
    output logic [$clog2(NCH)-1:0]   o_evt_ch,
    output logic                     o_evt_tar,
`ifdef AER_TIMESTAMP_EN
    output logic [TSW-1:0]           o_evt_ts,
`endif
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_stall
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
`ifdef AER_TIMESTAMP_EN
    localparam int unsigned WW = M + CW + 1 + TSW;
`else
    localparam int unsigned WW = M + CW + 1;
`endif
    localparam logic [LW-1:0] LvlFull   = LW'(DEPTH);
    localparam logic [LW-1:0] LvlAlmost = LW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StAck} ch_state_e;

    // ------------------------------------------------------------------
    // Request synchronisers
    // ------------------------------------------------------------------
    logic [NCH-1:0] r_req_meta;
    logic [NCH-1:0] r_req_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_req_meta <= '0;
            r_req_sync <= '0;
        end else begin
            r_req_meta <= i_aerin_req;
            r_req_sync <= r_req_meta;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp counter
    // ------------------------------------------------------------------
`ifdef AER_TIMESTAMP_EN
    logic           r_tick_meta;
    logic           r_tick_sync;
    logic           r_tick_prev;
    logic [TSW-1:0] r_ts;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tick_meta <= 1'b0;
            r_tick_sync <= 1'b0;
            r_tick_prev <= 1'b0;
            r_ts        <= '0;
        end else begin
            r_tick_meta <= i_time_tick;
            r_tick_sync <= r_tick_meta;
            r_tick_prev <= r_tick_sync;
            if (r_tick_sync && !r_tick_prev) begin
                r_ts <= r_ts + 1'b1;
            end
        end
    end
`else
    logic [TSW-1:0] w_unused_ts;
    assign w_unused_ts = {TSW{i_time_tick}};
`endif

    // ------------------------------------------------------------------
    // Channel FSMs: state register / next-state / outputs
    // ------------------------------------------------------------------
    ch_state_e r_ch_state [NCH];
    ch_state_e w_ch_state_d [NCH];
    logic      r_gnt_vld;
    logic [CW-1:0] r_gnt_ch;

    always_ff @(posedge i_clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!i_rst_n) begin
                r_ch_state[c] <= StIdle;
            end else begin
                r_ch_state[c] <= w_ch_state_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_ch_state_d[c] = r_ch_state[c];
            unique case (r_ch_state[c])
                StIdle: begin
                    // The grant cycle is the one where r_gnt_* names this channel.
                    if (r_gnt_vld && (r_gnt_ch == CW'(c))) begin
                        w_ch_state_d[c] = StAck;
                    end
                end
                StAck: begin
                    if (!r_req_sync[c]) begin
                        w_ch_state_d[c] = StIdle;
                    end
                end
                default: w_ch_state_d[c] = StIdle;
            endcase
        end
    end

    logic [NCH-1:0] w_idle;

    always_comb begin
        o_aerin_ack = '0;
        w_idle      = '0;
        for (int c = 0; c < NCH; c++) begin
            o_aerin_ack[c] = (r_ch_state[c] == StAck);
            w_idle[c]      = (r_ch_state[c] == StIdle);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter (grant is registered; push happens the cycle after)
    // ------------------------------------------------------------------
    logic [LW-1:0]  r_level;
    logic [CW-1:0]  r_rr_ptr;
    logic [NCH-1:0] w_gnt_mask;
    logic [NCH-1:0] w_cand;
    logic [NCH-1:0] w_pending;
    logic [CW:0]    w_idx;
    logic           w_arb_found;
    logic [CW-1:0]  w_arb_ch;
    logic           w_room;
    logic           w_grant;
    logic [CW-1:0]  w_ptr_next;

    // The channel already holding the grant is still IDLE this cycle; mask it.
    assign w_gnt_mask = r_gnt_vld ? (NCH'(1) << r_gnt_ch) : '0;
    assign w_pending  = r_req_sync & w_idle;
    assign w_cand     = w_pending & ~w_gnt_mask;

    always_comb begin
        w_idx       = '0;
        w_arb_found = 1'b0;
        w_arb_ch    = '0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (CW + 1)'(i);
            if (w_idx >= (CW + 1)'(NCH)) begin
                w_idx = w_idx - (CW + 1)'(NCH);
            end
            if (!w_arb_found && w_cand[w_idx[CW-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_ch    = w_idx[CW-1:0];
            end
        end
    end

    // Registered level only: a pop this cycle never frees room. An in-flight
    // grant reserves one slot so the following push always fits.
    assign w_room     = (r_level != LvlFull) && !(r_gnt_vld && (r_level == LvlAlmost));
    assign w_grant    = w_arb_found && w_room;
    assign w_ptr_next = (w_arb_ch == CW'(NCH - 1)) ? '0 : w_arb_ch + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt_vld <= 1'b0;
            r_gnt_ch  <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_gnt_vld <= w_grant;
            if (w_grant) begin
                r_gnt_ch <= w_arb_ch;
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [M-1:0]  w_push_addr;
    logic          w_push_tar;
    logic [WW-1:0] w_push_word;
    logic [WW-1:0] w_head;
    logic [WW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        w_push_addr = '0;
        w_push_tar  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (r_gnt_ch == CW'(c)) begin
                w_push_addr = i_aerin_addr[c*M +: M];
                w_push_tar  = i_aerin_tar_en[c];
            end
        end
    end

`ifdef AER_TIMESTAMP_EN
    assign w_push_word = {r_ts, w_push_tar, r_gnt_ch, w_push_addr};
`else
    assign w_push_word = {w_push_tar, r_gnt_ch, w_push_addr};
`endif

    assign w_push = r_gnt_vld;
    assign w_pop  = o_evt_valid && i_evt_ready;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign o_evt_valid  = (r_level != '0);
    assign o_evt_addr   = w_head[M-1:0];
    assign o_evt_ch     = w_head[M +: CW];
    assign o_evt_tar    = w_head[M+CW];
`ifdef AER_TIMESTAMP_EN
    assign o_evt_ts     = w_head[M+CW+1 +: TSW];
`endif
    assign o_fifo_level = r_level;

    // ------------------------------------------------------------------
    // Stall status
    // ------------------------------------------------------------------
    logic r_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= (|w_pending) && (r_level == LvlFull);
        end
    end

    assign o_stall = r_stall;

endmodule

// File: tb/tb_aer_in_arbiter.sv
// ----------------------------------------------------------------------------
// tb_aer_in_arbiter
//
// Directed bench for aer_in_arbiter (NCH=4, M=3, DEPTH=8, TSW=4). Inputs are
// driven and outputs sampled 1 time unit after the rising clock edge.
// ----------------------------------------------------------------------------
module tb_aer_in_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic [3:0]  req;
    logic [3:0]  tar;
    logic [3:0]  ack;
    logic        tick;
    logic        valid;
    logic        ready;
    logic [2:0]  eaddr;
    logic [1:0]  ech;
    logic        etar;
    logic [3:0]  level;
    logic        stall;
`ifdef AER_TIMESTAMP_EN
    logic [3:0]  ts;
`endif

    int errors = 0;
    int checks = 0;

    aer_in_arbiter #(
        .NCH   (4),
        .M     (3),
        .DEPTH (8),
        .TSW   (4)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_aerin_addr   (addr),
        .i_aerin_req    (req),
        .i_aerin_tar_en (tar),
        .o_aerin_ack    (ack),
        .i_time_tick    (tick),
        .o_evt_valid    (valid),
        .i_evt_ready    (ready),
        .o_evt_addr     (eaddr),
        .o_evt_ch       (ech),
        .o_evt_tar      (etar),
`ifdef AER_TIMESTAMP_EN
        .o_evt_ts       (ts),
`endif
        .o_fifo_level   (level),
        .o_stall        (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int c, input logic v, input string tag);
        for (int n = 0; n < 40 && ack[c] !== v; n++) step(1);
        chk(tag, 32'(ack[c]), 32'(v));
    endtask

    task automatic send(input int c, input logic [2:0] a, input logic t);
        addr[c*3 +: 3] = a;
        tar[c]         = t;
        req[c]         = 1'b1;
        wait_ack(c, 1'b1, "send_ack_rise");
        req[c]         = 1'b0;
        wait_ack(c, 1'b0, "send_ack_fall");
    endtask

    task automatic pop_chk(input string tag, input int c, input int a, input int t);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_ch"},    32'(ech),   32'(c));
        chk({tag, "_addr"},  32'(eaddr), 32'(a));
        chk({tag, "_tar"},   32'(etar),  32'(t));
        ready = 1'b1;
        step(1);
        ready = 1'b0;
    endtask

    int rec [8];
    int nrec;
    int ev_ch [9];
    int ev_a  [9];
    int ev_t  [9];

    initial begin
        // T1: reset with every request high
        rst_n = 1'b0;
        req   = 4'hF;
        tar   = 4'b0101;
        addr  = {3'd4, 3'd3, 3'd2, 3'd1};
        tick  = 1'b0;
        ready = 1'b0;
        step(2);
        chk("t1_rst_ack",   32'(ack),   32'h0);
        chk("t1_rst_valid", 32'(valid), 32'h0);
        chk("t1_rst_level", 32'(level), 32'h0);
        chk("t1_rst_stall", 32'(stall), 32'h0);
        rst_n = 1'b1;
        step(10);
        chk("t1_ack_all", 32'(ack),   32'hF);
        chk("t1_level",   32'(level), 32'd4);
        for (int k = 0; k < 4; k++) pop_chk("t1_order", k, k + 1, (k % 2 == 0) ? 1 : 0);
        req = 4'h0;
        step(4);
        chk("t1_ack_drop", 32'(ack), 32'h0);

        // T2: single handshake on channel 2, rise 4 CLK, fall 3 CLK
        addr[6 +: 3] = 3'd5;
        tar[2]       = 1'b1;
        req[2]       = 1'b1;
        step(3);
        chk("t2_ack_early", 32'(ack[2]), 32'd0);
        step(1);
        chk("t2_ack_rise", 32'(ack[2]), 32'd1);
        chk("t2_valid",    32'(valid),  32'd1);
        req[2] = 1'b0;
        step(2);
        chk("t2_ack_hold", 32'(ack[2]), 32'd1);
        step(1);
        chk("t2_ack_fall", 32'(ack[2]), 32'd0);
        pop_chk("t2_evt", 2, 5, 1);

        // T3: round-robin under continuous requests; pointer is 3 after T2
        nrec  = 0;
        ready = 1'b1;
        req   = 4'hF;
        for (int n = 0; n < 300 && nrec < 8; n++) begin
            if (valid) begin
                rec[nrec] = int'(ech);
                nrec++;
            end
            for (int c = 0; c < 4; c++) begin
                if (ack[c] && req[c]) req[c] = 1'b0;
                else if (!ack[c] && !req[c]) req[c] = 1'b1;
            end
            step(1);
        end
        chk("t3_count", 32'(nrec), 32'd8);
        for (int i = 0; i < 8; i++) chk("t3_order", 32'(rec[i]), 32'((3 + i) % 4));
        req = 4'h0;
        step(15);
        ready = 1'b0;
        chk("t3_drain_level", 32'(level), 32'd0);
        chk("t3_drain_ack",   32'(ack),   32'h0);

        // T4: fill to DEPTH, 9th event back-pressured until one pop
        for (int k = 0; k < 9; k++) begin
            ev_ch[k] = (k % 2 == 0) ? 1 : 3;
            ev_a[k]  = k;
            ev_t[k]  = k % 2;
        end
        ev_ch[8] = 1;
        ev_a[8]  = 7;
        ev_t[8]  = 0;
        for (int k = 0; k < 8; k++) send(ev_ch[k], 3'(ev_a[k]), 1'(ev_t[k]));
        chk("t4_level_full", 32'(level), 32'd8);
        addr[3 +: 3] = 3'd7;
        tar[1]       = 1'b0;
        req[1]       = 1'b1;
        step(10);
        chk("t4_ack_withheld", 32'(ack[1]), 32'd0);
        chk("t4_level_8",      32'(level),  32'd8);
        chk("t4_stall",        32'(stall),  32'd1);
        pop_chk("t4_pulse", ev_ch[0], ev_a[0], ev_t[0]);
        wait_ack(1, 1'b1, "t4_9th_ack");
        chk("t4_level_back", 32'(level), 32'd8);
        req[1] = 1'b0;
        wait_ack(1, 1'b0, "t4_9th_ack_fall");
        for (int k = 1; k < 9; k++) pop_chk("t4_order", ev_ch[k], ev_a[k], ev_t[k]);
        chk("t4_empty", 32'(level), 32'd0);
        chk("t4_stall_clear", 32'(stall), 32'd0);

        // T5: push and pop in the same cycle at level 3
        send(0, 3'd1, 1'b0);
        send(2, 3'd2, 1'b1);
        send(0, 3'd3, 1'b1);
        addr[3 +: 3] = 3'd4;
        tar[1]       = 1'b0;
        req[1]       = 1'b1;
        step(3);
        chk("t5_level_pre", 32'(level), 32'd3);
        chk("t5_head_pre",  32'(eaddr), 32'd1);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk("t5_level_same", 32'(level),  32'd3);
        chk("t5_ack",        32'(ack[1]), 32'd1);
        req[1] = 1'b0;
        wait_ack(1, 1'b0, "t5_ack_fall");
        pop_chk("t5_order", 2, 2, 1);
        pop_chk("t5_order", 0, 3, 1);
        pop_chk("t5_order", 1, 4, 0);

`ifdef AER_TIMESTAMP_EN
        // T6: 17 ticks with TSW=4 wrap to 1
        for (int k = 0; k < 17; k++) begin
            tick = 1'b1;
            step(3);
            tick = 1'b0;
            step(3);
        end
        step(4);
        send(0, 3'd6, 1'b1);
        chk("t6_ts", 32'(ts), 32'd1);
        pop_chk("t6_evt", 0, 6, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
